adc_tone_gen: RTL and testbench
===============================

Name: adc_tone_gen

Overview:
- Synthesizable, parametrised multi-channel test-signal source.
- Generalises the single-tone ADC stimulus model into NCH independent NCO tones with per-channel frequency and amplitude, optional LFSR noise, a saturating sum, and a left-justified ADC-format word.
- Drives the receiver datapath in place of the ADC, for on-board loopback and for benches.

Parameters:
- NCH, 2, number of tone channels (1..8).
- PHASE_W, 32, phase accumulator / frequency word width.
- LUT_AW, 10, sine LUT address bits (full wave, 2^LUT_AW entries).
- OUT_W, 10, signed sample width before justification.
- ADC_W, 16, output word width; sample placed in the MSBs.
- NOISE_W, 3, noise magnitude bits.

Ports:
- mclk  in  1  clock
- ext_rst  in  1  asynchronous reset, active-high
- ce  in  1  sample strobe; one output sample per ce
- sync_clr  in  1  zero all phase accumulators
- noise_en  in  1  add LFSR noise
- cfg_we  in  1  configuration write strobe
- cfg_ch  in  $clog2(NCH) (min 1)  target channel
- cfg_fword  in  PHASE_W  frequency word
- cfg_amp  in  8  unsigned gain; 128 = unity
- dout  out  OUT_W  signed sample
- adc  out  ADC_W  dout <<< (ADC_W-OUT_W), low bits zero
- dout_valid  out  1  sample valid pulse
- sat  out  1  pulse, coincident with dout_valid, when the sum clipped

Behaviour:
- Reset (asynchronous, active-high) clears:
  - all accumulators and fwords to 0; all amps to 0;
  - dout, adc, dout_valid and sat to 0;
  - pipeline valid bits to 0;
  - LFSR to 16'hACE1.
- Config:
  - cfg_we at cycle n updates fword[cfg_ch] and amp[cfg_ch], effective for any ce from cycle n+1.
  - Accumulator phase is not disturbed.
  - cfg_ch >= NCH: write ignored.
- Phase:
  - A sample taken on ce uses the current accumulator value p; the accumulator then becomes p + fword (mod 2^PHASE_W).
  - No ce: accumulators hold.
- sync_clr:
  - Sets all accumulators to 0 next cycle.
  - With ce in the same cycle, the sample uses phase 0 and the accumulator becomes fword.
  - Has no effect on samples already in flight.
- Pipeline, fixed latency 3: ce at cycle n gives dout_valid at n+3; ce every cycle is sustained with no bubbles.
  - S1: LUT index = p[PHASE_W-1 -: LUT_AW]; registered lut = round((2^(OUT_W-1)-1)·sin(2π·idx/2^LUT_AW)).
  - S2: scaled = (lut·amp) >>> 7, signed multiply, floor.
  - S3: sum of all channels + noise, clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; sat = 1 if clamped.
- Noise:
  - 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1, advances once per ce.
  - noise = sign-extended low NOISE_W bits when noise_en (sampled at ce), else 0.
- Output register:
  - dout and adc update only with dout_valid and hold otherwise.
  - dout_valid and sat are single-cycle pulses.
- Internal sum width OUT_W+$clog2(NCH)+2, so no overflow occurs before the clamp.

Decomposition:
- Package adc_tone_pkg holds:
  - sine_lut function, evaluated at elaboration;
  - LFSR seed and tap constants;
  - the amp_t (8-bit) typedef;
  - the UNITY_SHIFT=7 constant.
- Sub-module nco_channel (accumulator, fword/amp registers, LUT, scale stages), instantiated NCH times by generate; the top holds LFSR, adder tree, clamp and output.

Test Plan:
- Reset, NCH=1, fword=2^30, amp=128, ce every cycle → dout sequence 0, 511, 0, -511 repeating starting 3 cycles after first ce; adc 0x0000, 0x7FC0, 0x0000, 0x8040; sat=0.
- NCH=2, both fword=2^30, amp=255, ce continuous → second sample of each period: per-channel 1018, sum clamps to 511 with sat=1; fourth sample clamps to -512 with sat=1.
- sync_clr asserted with ce mid-stream (fword=2^30) → that sample outputs 0 three cycles later; next samples 511, 0, -511; the three in-flight samples before it are unchanged.
- cfg_we with cfg_ch=3 on NCH=2 → no output change; cfg_we fword=2^29 on ch0 mid-stream → phase continues from current value with new step from next ce; ce gated every 4th cycle → dout_valid exactly 3 cycles after each ce, dout holds between.
- noise_en=1, amp=0 → dout sequence equals sign-extended low 3 bits of the reference LFSR from seed 16'hACE1, each within [-4,3].
- ext_rst asserted asynchronously mid-stream → dout, adc, dout_valid and sat go to 0 immediately; after release, with no cfg_we, outputs remain 0 with ce.

Source files
------------

// File: rtl/adc_tone_pkg.sv
// Shared types and constants for the multi-channel tone source.
//   amp_t       : 8-bit unsigned channel gain, 128 = unity
//   UNITY_SHIFT : right shift that turns lut*amp back into sample units
//   LFSR_SEED   : reset value of the noise LFSR
//   LFSR_TAPS   : Galois mask for x^16+x^14+x^13+x^11+1 (right-shifting form)
//   ch_width()  : channel-select width, never below 1 bit
//   sine_lut()  : one rounded sine table entry, used only at elaboration
package adc_tone_pkg;

  typedef logic [7:0] amp_t;

  localparam int          UNITY_SHIFT = 7;
  localparam logic [15:0] LFSR_SEED   = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;
  localparam real         PI_R        = 3.14159265358979323846;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // round((2^(out_w-1)-1) * sin(2*pi*idx/2^lut_aw)), rounding half away from zero
  function automatic int sine_lut(input int idx, input int lut_aw, input int out_w);
    real peak;
    real x;
    peak = real'((1 << (out_w - 1)) - 1);
    x    = peak * $sin(2.0 * PI_R * real'(idx) / real'(1 << lut_aw));
    if (x >= 0.0) return $rtoi(x + 0.5);
    else          return -$rtoi(0.5 - x);
  endfunction

endpackage

// File: rtl/adc_tone_nco_channel.sv
// One tone channel: phase accumulator, frequency/gain registers, sine LUT
// (stage 1) and gain scaling (stage 2).
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_ce          : sample strobe
//   i_sync_clr    : force phase to zero for this and following samples
//   i_we          : load i_fword / i_amp into this channel
//   o_scaled      : (lut * amp) >>> 7, two stages after the strobe
module nco_channel
  import adc_tone_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 10,
  parameter int OUT_W   = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ce,
  input  logic                  i_sync_clr,
  input  logic                  i_we,
  input  logic [PHASE_W-1:0]    i_fword,
  input  amp_t                  i_amp,
  output logic signed [OUT_W:0] o_scaled
);

  localparam int LUT_N  = 1 << LUT_AW;
  localparam int PROD_W = OUT_W + 9;

  logic [PHASE_W-1:0]      r_acc;
  logic [PHASE_W-1:0]      r_fword;
  amp_t                    r_amp;
  amp_t                    r_amp_s1;
  logic signed [OUT_W-1:0] r_lut;
  logic signed [OUT_W:0]   r_scaled;

  logic signed [OUT_W-1:0] w_lut [LUT_N];
  logic [PHASE_W-1:0]      w_phase;
  logic signed [PROD_W-1:0] w_prod;

  for (genvar g = 0; g < LUT_N; g++) begin : g_lut
    localparam int LUT_V = sine_lut(g, LUT_AW, OUT_W);
    assign w_lut[g] = LUT_V[OUT_W-1:0];
  end

  // sync_clr takes effect on the sample issued in the same cycle
  assign w_phase = i_sync_clr ? '0 : r_acc;

  // gain travels with its sample so a later config write cannot reach back
  assign w_prod = PROD_W'(r_lut) * PROD_W'($signed({1'b0, r_amp_s1}));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc    <= '0;
      r_fword  <= '0;
      r_amp    <= '0;
      r_amp_s1 <= '0;
      r_lut    <= '0;
      r_scaled <= '0;
    end else begin
      if (i_we) begin
        r_fword <= i_fword;
        r_amp   <= i_amp;
      end
      if (i_ce) begin
        r_acc    <= w_phase + r_fword;
        r_lut    <= w_lut[w_phase[PHASE_W-1 -: LUT_AW]];
        r_amp_s1 <= r_amp;
      end else if (i_sync_clr) begin
        r_acc <= '0;
      end
      r_scaled <= (OUT_W+1)'(w_prod >>> UNITY_SHIFT);
    end
  end

  assign o_scaled = r_scaled;

endmodule

// File: rtl/adc_tone_gen.sv
// Multi-channel test-signal source standing in for the ADC. NCH tone
// channels plus optional LFSR noise are summed, clamped to OUT_W bits and
// presented both as a signed sample and as a left-justified ADC word.
// Latency from ce to dout_valid is three clocks.
//   mclk, ext_rst      : clock, asynchronous active-high reset
//   ce                 : sample strobe
//   sync_clr           : zero every phase accumulator
//   noise_en           : add LFSR noise to the sample issued with ce
//   cfg_we/ch/fword/amp: per-channel frequency and gain write
//   dout, adc          : signed sample, sample in the ADC word MSBs
//   dout_valid, sat    : sample pulse, clamp indicator pulse
module adc_tone_gen
  import adc_tone_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 10,
  parameter int OUT_W   = 10,
  parameter int ADC_W   = 16,
  parameter int NOISE_W = 3
) (
  input  logic                      mclk,
  input  logic                      ext_rst,
  input  logic                      ce,
  input  logic                      sync_clr,
  input  logic                      noise_en,
  input  logic                      cfg_we,
  input  logic [ch_width(NCH)-1:0]  cfg_ch,
  input  logic [PHASE_W-1:0]        cfg_fword,
  input  amp_t                      cfg_amp,
  output logic signed [OUT_W-1:0]   dout,
  output logic [ADC_W-1:0]          adc,
  output logic                      dout_valid,
  output logic                      sat
);

  localparam int CH_W   = ch_width(NCH);
  localparam int SUM_W  = OUT_W + $clog2(NCH) + 2;
  localparam int MAX_I  = (1 << (OUT_W - 1)) - 1;
  localparam int MIN_I  = -(1 << (OUT_W - 1));
  localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(MAX_I);
  localparam logic signed [SUM_W-1:0] SUM_MIN = SUM_W'(MIN_I);

  logic [15:0]               r_lfsr;
  logic [NOISE_W-1:0]        r_noise_s1;
  logic [NOISE_W-1:0]        r_noise_s2;
  logic                      r_v1;
  logic                      r_v2;
  logic                      r_valid;
  logic                      r_sat;
  logic signed [OUT_W-1:0]   r_dout;

  logic [NCH-1:0]            w_we;
  logic signed [OUT_W:0]     w_scaled [NCH];
  logic signed [SUM_W-1:0]   w_sum;
  logic signed [OUT_W-1:0]   w_clip;
  logic                      w_sat;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    // codes at or above NCH match no channel and are dropped
    assign w_we[g] = cfg_we && (cfg_ch == CH_W'(g));

    nco_channel #(
      .PHASE_W (PHASE_W),
      .LUT_AW  (LUT_AW),
      .OUT_W   (OUT_W)
    ) u_ch (
      .i_clk      (mclk),
      .i_rst      (ext_rst),
      .i_ce       (ce),
      .i_sync_clr (sync_clr),
      .i_we       (w_we[g]),
      .i_fword    (cfg_fword),
      .i_amp      (cfg_amp),
      .o_scaled   (w_scaled[g])
    );
  end

  always_comb begin
    w_sum = {{(SUM_W-NOISE_W){r_noise_s2[NOISE_W-1]}}, r_noise_s2};
    for (int i = 0; i < NCH; i++) begin
      w_sum = w_sum + {{(SUM_W-OUT_W-1){w_scaled[i][OUT_W]}}, w_scaled[i]};
    end
  end

  always_comb begin
    w_clip = w_sum[OUT_W-1:0];
    w_sat  = 1'b0;
    if (w_sum > SUM_MAX) begin
      w_clip = SUM_MAX[OUT_W-1:0];
      w_sat  = 1'b1;
    end else if (w_sum < SUM_MIN) begin
      w_clip = SUM_MIN[OUT_W-1:0];
      w_sat  = 1'b1;
    end
  end

  always_ff @(posedge mclk or posedge ext_rst) begin
    if (ext_rst) begin
      r_lfsr     <= LFSR_SEED;
      r_noise_s1 <= '0;
      r_noise_s2 <= '0;
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_valid    <= 1'b0;
      r_sat      <= 1'b0;
      r_dout     <= '0;
    end else begin
      r_v1    <= ce;
      r_v2    <= r_v1;
      r_valid <= r_v2;
      r_sat   <= r_v2 & w_sat;
      if (r_v2) r_dout <= w_clip;
      // noise for a sample is the LFSR state at its strobe, before the step
      r_noise_s1 <= (ce && noise_en) ? r_lfsr[NOISE_W-1:0] : '0;
      r_noise_s2 <= r_noise_s1;
      if (ce) r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign dout       = r_dout;
  assign adc        = ADC_W'(r_dout) << (ADC_W - OUT_W);
  assign dout_valid = r_valid;
  assign sat        = r_sat;

endmodule

// File: tb/tb_adc_tone_gen.sv
module tb_adc_tone_gen;

  localparam int NCH = 3;

  logic               mclk = 1'b0;
  logic               ext_rst;
  logic               ce;
  logic               sync_clr;
  logic               noise_en;
  logic               cfg_we;
  logic [1:0]         cfg_ch;
  logic [31:0]        cfg_fword;
  logic [7:0]         cfg_amp;
  logic signed [9:0]  dout;
  logic [15:0]        adc;
  logic               dout_valid;
  logic               sat;

  adc_tone_gen #(
    .NCH(NCH), .PHASE_W(32), .LUT_AW(10), .OUT_W(10), .ADC_W(16), .NOISE_W(3)
  ) dut (
    .mclk       (mclk),
    .ext_rst    (ext_rst),
    .ce         (ce),
    .sync_clr   (sync_clr),
    .noise_en   (noise_en),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_fword  (cfg_fword),
    .cfg_amp    (cfg_amp),
    .dout       (dout),
    .adc        (adc),
    .dout_valid (dout_valid),
    .sat        (sat)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    int dout;
    bit sat;
    int due;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] m_acc [NCH];
  logic [31:0] m_fw  [NCH];
  int          m_amp [NCH];
  logic [15:0] m_lfsr;

  function automatic int ref_sine(input int idx);
    real x;
    x = 511.0 * $sin(2.0 * 3.14159265358979323846 * real'(idx) / 1024.0);
    if (x >= 0.0) return int'($floor(x + 0.5));
    else          return -int'($floor(-x + 0.5));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_acc[k] = '0; m_fw[k] = '0; m_amp[k] = 0;
    end
    m_lfsr = 16'hACE1;
    sb.delete();
  endtask

  // drives one cycle of inputs and pushes the expected sample for a strobe
  task automatic drive(input bit c, input bit s, input bit nz, input bit we,
                       input int ch, input logic [31:0] fw, input int amp);
    exp_t        e;
    int          sum;
    int          lut;
    logic [31:0] ph;
    logic [9:0]  idx;
    logic [1:0]  ch2;
    logic [7:0]  amp8;
    ch2  = ch[1:0];
    amp8 = amp[7:0];
    ce = c; sync_clr = s; noise_en = nz; cfg_we = we;
    cfg_ch = ch2; cfg_fword = fw; cfg_amp = amp8;
    if (c) begin
      sum = nz ? ((int'(m_lfsr[2:0]) ^ 4) - 4) : 0;
      for (int k = 0; k < NCH; k++) begin
        ph  = s ? 32'd0 : m_acc[k];
        idx = ph[31:22];
        lut = ref_sine(int'(idx));
        sum += (lut * m_amp[k]) >>> 7;
        m_acc[k] = ph + m_fw[k];
      end
      e.sat = 1'b0;
      if (sum > 511) begin sum = 511; e.sat = 1'b1; end
      else if (sum < -512) begin sum = -512; e.sat = 1'b1; end
      e.dout = sum;
      e.due  = cyc + 3;
      sb.push_back(e);
      m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end else if (s) begin
      for (int k = 0; k < NCH; k++) m_acc[k] = '0;
    end
    if (we && ch < NCH) begin
      m_fw[ch]  = fw;
      m_amp[ch] = amp;
    end
  endtask

  task automatic test_reset();
    ext_rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge mclk);
    n_checks++;
    if (dout !== 10'd0 || adc !== 16'h0000 || dout_valid !== 1'b0 || sat !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: dout=%0d adc=%h valid=%b sat=%b, required all zero", dout, adc, dout_valid, sat);
    end
    ext_rst = 1'b0;
  endtask

  task automatic test_single_tone();
    exp_t        e;
    logic [15:0] ea;
    int          k = 0;
    int          seq_d[4] = '{0, 511, 0, -511};
    logic [15:0] seq_a[4] = '{16'h0000, 16'h7FC0, 16'h0000, 16'h8040};
    for (int i = 0; i < 18; i++) begin
      @(negedge mclk); cyc++;
      if (dout_valid) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++; $display("FAIL single_valid: unexpected dout_valid at cycle %0d", cyc);
        end else begin
          e = sb.pop_front(); ea = 16'(e.dout) << 6;
          if (cyc !== e.due || dout !== 10'(e.dout) || adc !== ea || sat !== e.sat) begin
            n_errors++;
            $display("FAIL single_sample: cyc=%0d dout=%0d adc=%h sat=%b, required cyc=%0d dout=%0d adc=%h sat=%b", cyc, dout, adc, sat, e.due, e.dout, ea, e.sat);
          end
        end
        n_checks++;
        if (dout !== 10'(seq_d[k % 4]) || adc !== seq_a[k % 4] || sat !== 1'b0) begin
          n_errors++;
          $display("FAIL single_table[%0d]: dout=%0d adc=%h sat=%b, required dout=%0d adc=%h sat=0", k, dout, adc, sat, seq_d[k % 4], seq_a[k % 4]);
        end
        k++;
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        n_checks++; n_errors++;
        $display("FAIL single_missing: no dout_valid at cycle %0d, required at %0d", cyc, sb[0].due);
        void'(sb.pop_front());
      end
      if (i == 0)       drive(0, 0, 0, 1, 0, 32'h4000_0000, 128);
      else if (i <= 12) drive(1, 0, 0, 0, 0, 0, 0);
      else              drive(0, 0, 0, 0, 0, 0, 0);
    end
    n_checks++;
    if (k != 12) begin
      n_errors++; $display("FAIL single_count: samples=%0d, required 12", k);
    end
  endtask

  task automatic test_two_tone_clip();
    exp_t        e;
    logic [15:0] ea;
    int          k = 0;
    int          seq_d[4] = '{0, 511, 0, -512};
    bit          seq_s[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 14; i++) begin
      @(negedge mclk); cyc++;
      if (dout_valid) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++; $display("FAIL clip_valid: unexpected dout_valid at cycle %0d", cyc);
        end else begin
          e = sb.pop_front(); ea = 16'(e.dout) << 6;
          if (cyc !== e.due || dout !== 10'(e.dout) || adc !== ea || sat !== e.sat) begin
            n_errors++;
            $display("FAIL clip_sample: cyc=%0d dout=%0d adc=%h sat=%b, required cyc=%0d dout=%0d adc=%h sat=%b", cyc, dout, adc, sat, e.due, e.dout, ea, e.sat);
          end
        end
        n_checks++;
        if (dout !== 10'(seq_d[k % 4]) || sat !== seq_s[k % 4]) begin
          n_errors++;
          $display("FAIL clip_table[%0d]: dout=%0d sat=%b, required dout=%0d sat=%b", k, dout, sat, seq_d[k % 4], seq_s[k % 4]);
        end
        k++;
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        n_checks++; n_errors++;
        $display("FAIL clip_missing: no dout_valid at cycle %0d, required at %0d", cyc, sb[0].due);
        void'(sb.pop_front());
      end
      if (i == 0)      drive(0, 0, 0, 1, 1, 32'h4000_0000, 255);
      else if (i == 1) drive(0, 0, 0, 1, 0, 32'h4000_0000, 255);
      else if (i <= 9) drive(1, i == 2, 0, 0, 0, 0, 0);
      else             drive(0, 0, 0, 0, 0, 0, 0);
    end
    n_checks++;
    if (k != 8) begin
      n_errors++; $display("FAIL clip_count: samples=%0d, required 8", k);
    end
  endtask

  task automatic test_sync_clr();
    exp_t        e;
    logic [15:0] ea;
    for (int i = 0; i < 18; i++) begin
      @(negedge mclk); cyc++;
      if (dout_valid) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++; $display("FAIL sync_valid: unexpected dout_valid at cycle %0d", cyc);
        end else begin
          e = sb.pop_front(); ea = 16'(e.dout) << 6;
          if (cyc !== e.due || dout !== 10'(e.dout) || adc !== ea || sat !== e.sat) begin
            n_errors++;
            $display("FAIL sync_sample: cyc=%0d dout=%0d adc=%h sat=%b, required cyc=%0d dout=%0d adc=%h sat=%b", cyc, dout, adc, sat, e.due, e.dout, ea, e.sat);
          end
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        n_checks++; n_errors++;
        $display("FAIL sync_missing: no dout_valid at cycle %0d, required at %0d", cyc, sb[0].due);
        void'(sb.pop_front());
      end
      if (i == 0)       drive(0, 0, 0, 1, 1, 32'h0, 0);
      else if (i == 1)  drive(0, 0, 0, 1, 0, 32'h4000_0000, 128);
      else if (i <= 13) drive(1, i == 7, 0, 0, 0, 0, 0);
      else              drive(0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_cfg_gated();
    exp_t        e;
    logic [15:0] ea;
    logic [9:0]  last_d = '0;
    logic [15:0] last_a = '0;
    bit          have = 1'b0;
    for (int i = 0; i < 36; i++) begin
      @(negedge mclk); cyc++;
      if (dout_valid) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++; $display("FAIL cfg_valid: unexpected dout_valid at cycle %0d", cyc);
        end else begin
          e = sb.pop_front(); ea = 16'(e.dout) << 6;
          if (cyc !== e.due || dout !== 10'(e.dout) || adc !== ea || sat !== e.sat) begin
            n_errors++;
            $display("FAIL cfg_sample: cyc=%0d dout=%0d adc=%h sat=%b, required cyc=%0d dout=%0d adc=%h sat=%b", cyc, dout, adc, sat, e.due, e.dout, ea, e.sat);
          end
        end
        last_d = dout; last_a = adc; have = 1'b1;
      end else begin
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          n_checks++; n_errors++;
          $display("FAIL cfg_missing: no dout_valid at cycle %0d, required at %0d", cyc, sb[0].due);
          void'(sb.pop_front());
        end
        if (have) begin
          n_checks++;
          if (dout !== last_d || adc !== last_a || sat !== 1'b0) begin
            n_errors++;
            $display("FAIL cfg_hold: cyc=%0d dout=%0d adc=%h sat=%b, required dout=%0d adc=%h sat=0", cyc, dout, adc, sat, $signed(last_d), last_a);
          end
        end
      end
      if (i <= 5)       drive(1, 0, 0, i == 2, 3, 32'h0, 255);
      else if (i == 6)  drive(1, 0, 0, 1, 0, 32'h2000_0000, 128);
      else if (i <= 30) drive(i % 4 == 3, 0, 0, 0, 0, 0, 0);
      else              drive(0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_noise();
    exp_t        e;
    logic [15:0] ea;
    for (int i = 0; i < 21; i++) begin
      @(negedge mclk); cyc++;
      if (dout_valid) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++; $display("FAIL noise_valid: unexpected dout_valid at cycle %0d", cyc);
        end else begin
          e = sb.pop_front(); ea = 16'(e.dout) << 6;
          if (cyc !== e.due || dout !== 10'(e.dout) || adc !== ea || sat !== e.sat) begin
            n_errors++;
            $display("FAIL noise_sample: cyc=%0d dout=%0d adc=%h sat=%b, required cyc=%0d dout=%0d adc=%h sat=%b", cyc, dout, adc, sat, e.due, e.dout, ea, e.sat);
          end
        end
        n_checks++;
        if (int'(dout) < -4 || int'(dout) > 3) begin
          n_errors++; $display("FAIL noise_range: dout=%0d, required within [-4,3]", dout);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        n_checks++; n_errors++;
        $display("FAIL noise_missing: no dout_valid at cycle %0d, required at %0d", cyc, sb[0].due);
        void'(sb.pop_front());
      end
      if (i == 0)       drive(0, 0, 0, 1, 0, 32'h4000_0000, 0);
      else if (i <= 16) drive(1, 0, i != 6, 0, 0, 0, 0);
      else              drive(0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_async_reset();
    exp_t        e;
    logic [15:0] ea;
    for (int i = 0; i < 9; i++) begin
      @(negedge mclk); cyc++;
      if (dout_valid) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++; $display("FAIL arst_pre_valid: unexpected dout_valid at cycle %0d", cyc);
        end else begin
          e = sb.pop_front(); ea = 16'(e.dout) << 6;
          if (cyc !== e.due || dout !== 10'(e.dout) || adc !== ea || sat !== e.sat) begin
            n_errors++;
            $display("FAIL arst_pre_sample: cyc=%0d dout=%0d adc=%h, required cyc=%0d dout=%0d adc=%h", cyc, dout, adc, e.due, e.dout, ea);
          end
        end
      end
      if (i == 0) drive(0, 0, 0, 1, 0, 32'h4000_0000, 128);
      else        drive(1, i == 1, 0, 0, 0, 0, 0);
    end
    @(posedge mclk);
    #2 ext_rst = 1'b1;
    #1;
    n_checks++;
    if (dout !== 10'd0 || adc !== 16'h0000 || dout_valid !== 1'b0 || sat !== 1'b0) begin
      n_errors++;
      $display("FAIL arst_immediate: dout=%0d adc=%h valid=%b sat=%b, required all zero", dout, adc, dout_valid, sat);
    end
    @(negedge mclk); cyc++;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    ext_rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge mclk); cyc++;
      n_checks++;
      if (dout !== 10'd0 || adc !== 16'h0000 || sat !== 1'b0) begin
        n_errors++;
        $display("FAIL arst_after: cyc=%0d dout=%0d adc=%h sat=%b, required zero", cyc, dout, adc, sat);
      end
      if (dout_valid) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++; $display("FAIL arst_valid: unexpected dout_valid at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          if (cyc !== e.due || dout !== 10'(e.dout)) begin
            n_errors++;
            $display("FAIL arst_sample: cyc=%0d dout=%0d, required cyc=%0d dout=%0d", cyc, dout, e.due, e.dout);
          end
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        n_checks++; n_errors++;
        $display("FAIL arst_missing: no dout_valid at cycle %0d, required at %0d", cyc, sb[0].due);
        void'(sb.pop_front());
      end
      if (i <= 9) drive(1, 0, 0, 0, 0, 0, 0);
      else        drive(0, 0, 0, 0, 0, 0, 0);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++; $display("FAIL arst_drain: %0d samples outstanding, required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_tone();
    test_two_tone_clip();
    test_sync_clr();
    test_cfg_gated();
    test_noise();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
